instr_encode: RTL
=================

# instr_encode

Instruction encoder and program loader: the packing counterpart of the 30-bit instruction decoder. It accepts decoded instruction fields over a valid/ready handshake, packs them into 30-bit instruction words, and emits each word with a sequential instruction-memory write address. A 2-entry output buffer decouples the field source from the memory writer.

## Interface
- `ADDR_W`, default 10: write-address width; program depth is 2^ADDR_W words.
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `clear`  in  1  synchronous flush: buffer emptied, address 0, state IDLE, `err_count` 0
- `in_valid`  in  1  field bundle valid
- `in_ready`  out  1  encoder can accept
- `in_flag`  in  2  0 NOP, 1 ALU reg-reg, 2 ALU extended, 3 memory
- `in_oper`  in  4  ALU operation
- `in_rega` / `in_regb`  in  6  register indices
- `in_imm`  in  16  immediate
- `in_mem_op`  in  2  memory operation
- `in_mem_addr`  in  10  memory address
- `in_last`  in  1  final instruction of program
- `out_valid`  out  1  word valid
- `out_ready`  in  1  memory writer accepts
- `out_instr`  out  30  encoded word
- `out_addr`  out  ADDR_W  write address of `out_instr`
- `done`  out  1  one-cycle pulse, program fully drained
- `err`  out  1  one-cycle pulse, illegal bundle dropped
- `err_count`  out  8  saturating count of dropped bundles
- `prog_full`  out  1  high while in FULL

## Operation
- Encoding (unlisted bits 0):
  - flag 0: all-zero word.
  - flag 1: [29:28]=1, [27:24]=oper, [23:18]=rega, [17:12]=regb.
  - flag 2, oper 2: same layout as flag 1 with [29:28]=2.
  - flag 2, oper 3: [27:24]=3, [23:18]=rega, [15:0]=imm.
  - flag 2, any other oper: illegal.
  - flag 3, mem_op 1 or 2: [27:26]=mem_op, [25:20]=rega, [19:10]=mem_addr.
  - flag 3, mem_op 0 or 3: [27:26]=mem_op, [25:16]=mem_addr, [15:0]=imm.
- Accept = `in_valid & in_ready`. A legal bundle is pushed into the buffer with the current address counter; the counter increments. An illegal bundle is dropped: no push, no address consumed, `err` pulses, `err_count` increments (saturates at 255).
- States:
  - IDLE: counter 0.
  - RUN: entered on first accept.
  - DRAIN: entered on an accept with `in_last` (legal or illegal); `in_ready`=0; when the buffer is empty, `done` pulses and state returns to IDLE with counter 0.
  - FULL: entered when the word at address 2^ADDR_W-1 is accepted without `in_last`; `in_ready`=0; exits only via `clear` or reset. The buffer still drains.
- `in_last` on the final address goes to DRAIN, not FULL.
- `in_ready` = buffer not full and state is IDLE or RUN.
- `clear` has priority over every event in the same cycle.

## Timing
- Reset: all outputs 0, state IDLE. `in_ready` is 1 on the first cycle after reset release.
- Latency: accept in cycle N gives `out_valid` in N+1 when the buffer was empty. The word holds stable until `out_ready`.
- Buffer full (2 words, `out_ready` low): `in_ready` is 0 in the same cycle that the second push becomes visible. Simultaneous push and pop on a full buffer is not possible because `in_ready`=0.
- Simultaneous push and pop on a 1-entry buffer: occupancy stays 1, order is preserved.
- `err` and `done` are registered, asserted in the cycle after their cause.
- `out_valid` never drops without a handshake except on reset or `clear`.

## Structure
- Package `instr_pkg` holds:
  - `INSTR_W`=30.
  - Flag constants FLAG_NOP/ALU/EXT/MEM.
  - Field bit-position localparams.
  - State enum.
  - An `encode_instr` function returning the word plus an illegal bit, shared with the decoder bench.
- Sub-module `sync_fifo2`: a 2-entry FIFO carrying the {addr, instr} payload.

## Test plan
- flag 1, oper 5, rega 3, regb 7, `out_ready`=1 -> next cycle `out_instr`=0x150C_7000, `out_addr`=0.
- flag 2/oper 3/rega 10/imm 0xBEEF, then flag 3/mem_op 1/rega 4/mem_addr 0x155, then flag 3/mem_op 0/mem_addr 0x3FF/imm 0x1234 -> 0x2328_BEEF @0, 0x3445_5400 @1, 0x33FF_1234 @2.
- flag 2, oper 7, then a legal bundle -> no word for the first, `err` pulse, `err_count`=1; the legal word gets address 0.
- `out_ready`=0, three bundles offered back-to-back -> two accepted and `in_ready`=0. Raise `out_ready` -> words leave in order at addresses 0, 1, then the third is accepted.
- Stream with `in_last` on the 4th -> `in_ready`=0 after it; `done` pulses one cycle after the 4th word handshakes; the next program starts at address 0.
- 1024 legal bundles, no `in_last` -> `prog_full`=1 and `in_ready`=0 after address 1023. Assert `clear` -> IDLE, address 0; also check `rst_n` low mid-stream drops `out_valid` next cycle.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared definitions for the 30-bit instruction format: field positions,
// flag codes, loader states and the reference field-to-word packer.
package instr_pkg;

    localparam int INSTR_W = 30;

    localparam logic [1:0] FLAG_NOP = 2'd0;
    localparam logic [1:0] FLAG_ALU = 2'd1;
    localparam logic [1:0] FLAG_EXT = 2'd2;
    localparam logic [1:0] FLAG_MEM = 2'd3;

    localparam logic [3:0] OPER_EXT_RR  = 4'd2;
    localparam logic [3:0] OPER_EXT_IMM = 4'd3;

    localparam int FLAG_LSB      = 28;
    localparam int OPER_LSB      = 24;
    localparam int REGA_LSB      = 18;
    localparam int REGB_LSB      = 12;
    localparam int IMM_LSB       = 0;
    localparam int MOP_LSB       = 26;
    localparam int MREGA_LSB     = 20;
    localparam int MADDR_LSB     = 10;
    localparam int MADDR_IMM_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FULL
    } state_t;

    typedef struct packed {
        logic               illegal;
        logic [INSTR_W-1:0] word;
    } enc_t;

    function automatic enc_t encode_instr(
        input logic [1:0]  flag,
        input logic [3:0]  oper,
        input logic [5:0]  rega,
        input logic [5:0]  regb,
        input logic [15:0] imm,
        input logic [1:0]  mem_op,
        input logic [9:0]  mem_addr
    );
        enc_t r;
        r.illegal = 1'b0;
        r.word    = '0;
        case (flag)
            FLAG_NOP: ;
            FLAG_ALU: begin
                r.word[FLAG_LSB +: 2] = flag;
                r.word[OPER_LSB +: 4] = oper;
                r.word[REGA_LSB +: 6] = rega;
                r.word[REGB_LSB +: 6] = regb;
            end
            FLAG_EXT: begin
                r.word[FLAG_LSB +: 2] = flag;
                r.word[OPER_LSB +: 4] = oper;
                r.word[REGA_LSB +: 6] = rega;
                if (oper == OPER_EXT_RR) begin
                    r.word[REGB_LSB +: 6] = regb;
                end else if (oper == OPER_EXT_IMM) begin
                    r.word[IMM_LSB +: 16] = imm;
                end else begin
                    r.illegal = 1'b1;
                end
            end
            FLAG_MEM: begin
                r.word[FLAG_LSB +: 2] = flag;
                r.word[MOP_LSB +: 2]  = mem_op;
                // Loads/stores carry a register; the other two ops carry an immediate.
                if (mem_op == 2'd1 || mem_op == 2'd2) begin
                    r.word[MREGA_LSB +: 6]  = rega;
                    r.word[MADDR_LSB +: 10] = mem_addr;
                end else begin
                    r.word[MADDR_IMM_LSB +: 10] = mem_addr;
                    r.word[IMM_LSB +: 16]       = imm;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO with registered occupancy; the head entry is
// presented combinationally and reads as zero while the FIFO is empty.
module sync_fifo2 #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic             full,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign valid   = (count != 2'd0);
    assign full    = (count == 2'd2);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & valid;
    assign data    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // NOTE: storage is deliberately not reset; the empty-gated data output keeps
    // stale entries invisible, and leaving the array out of reset keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_encode.sv
// Instruction encoder and program loader: packs decoded field bundles into
// 30-bit words and emits them with sequential instruction-memory addresses.
module instr_encode
    import instr_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_flag,
    input  logic [3:0]         in_oper,
    input  logic [5:0]         in_rega,
    input  logic [5:0]         in_regb,
    input  logic [15:0]        in_imm,
    input  logic [1:0]         in_mem_op,
    input  logic [9:0]         in_mem_addr,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               done,
    output logic               err,
    output logic [7:0]         err_count,
    output logic               prog_full
);

    localparam int                PAYLOAD_W = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    state_t                state;
    logic [ADDR_W-1:0]     addr;
    enc_t                  enc;
    logic                  accept;
    logic                  push;
    logic                  drained;
    logic                  fifo_full;
    logic                  fifo_valid;
    logic [1:0]            fifo_count;
    logic [PAYLOAD_W-1:0]  fifo_data;

    assign enc = encode_instr(in_flag, in_oper, in_rega, in_regb, in_imm,
                              in_mem_op, in_mem_addr);

    // NOTE: in_ready is decoded from registered state, so it is gated with rst_n
    // to stay low while reset is held and rise in the first cycle after release.
    assign in_ready  = rst_n & ~fifo_full & (state == ST_IDLE || state == ST_RUN);
    assign accept    = in_valid & in_ready & ~clear;
    assign push      = accept & ~enc.illegal;
    assign drained   = (fifo_count == 2'd0) || (fifo_count == 2'd1 && out_ready);
    assign prog_full = (state == ST_FULL);
    assign out_valid = fifo_valid;
    assign {out_addr, out_instr} = fifo_data;

    sync_fifo2 #(
        .WIDTH(PAYLOAD_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .push     (push),
        .push_data({addr, enc.word}),
        .pop      (out_ready),
        .valid    (fifo_valid),
        .full     (fifo_full),
        .count    (fifo_count),
        .data     (fifo_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state     <= ST_IDLE;
            addr      <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err  <= accept & enc.illegal;
            done <= 1'b0;
            if (accept && enc.illegal && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (push) addr <= addr + 1'b1;
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (accept) begin
                        if (in_last)                               state <= ST_DRAIN;
                        else if (!enc.illegal && addr == ADDR_LAST) state <= ST_FULL;
                        else                                       state <= ST_RUN;
                    end
                end
                // Finish once the last queued word leaves at this edge.
                ST_DRAIN: begin
                    if (drained) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                        addr  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
